ddr3_read_checker: RTL and testbench
====================================

DDR3_READ_CHECKER -- requirements
Module: ddr3_read_checker

Interface
REQ-001 Parameter COUNT_WIDTH, default 24: width of the word-count, index and progress counters.
REQ-002 Parameter LFSR_POLY, default 32'h80200003: Galois LFSR feedback taps (x^32+x^22+x^2+x+1).
REQ-003 clk  input  1  single clock for all logic; the block SHALL use rising-edge logic only.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse that begins a check run.
REQ-006 seed  input  32  LFSR seed, sampled on an accepted start.
REQ-007 word_count  input  COUNT_WIDTH  number of 512-bit words to check, sampled on an accepted start.
REQ-008 ob_re  output  1  read enable to the output-buffer FIFO read port.
REQ-009 ob_rd_data  input  512  FIFO read data.
REQ-010 ob_rd_valid  input  1  ob_rd_data valid, asserted 1+ cycles after ob_re.
REQ-011 ob_empty  input  1  FIFO empty flag.
REQ-012 busy  output  1  run in progress.
REQ-013 done  output  1  run complete, held until the next accepted start.
REQ-014 pass  output  1  done with error_count==0.
REQ-015 error_count  output  32  total mismatching 32-bit lanes, saturating.
REQ-016 first_err_index  output  COUNT_WIDTH  word index of the first mismatch.
REQ-017 first_err_lane  output  4  lowest mismatching lane within that word.
REQ-018 words_checked  output  COUNT_WIDTH  words compared so far.

Function
REQ-019 Expected word: 16 lanes of 32 bits; lane 0 = ob_rd_data[31:0] up to lane 15 = [511:480]; each lane SHALL take the current LFSR state, then the LFSR SHALL advance one step, lane 0 first.
REQ-020 LFSR step: next = (state>>1) XOR (state[0] ? LFSR_POLY : 0); a seed of 0 SHALL be loaded as 32'h00000001.
REQ-021 State machine: S_IDLE, S_REQ, S_WAIT, S_CHECK, S_DONE.
REQ-022 S_IDLE/S_DONE: on start, the block SHALL load seed and word_count, clear all counters, error outputs, done and pass, and set busy; next state is S_DONE if word_count==0, otherwise S_REQ.
REQ-023 S_REQ: if !ob_empty, the block SHALL drive ob_re high for exactly one cycle and go to S_WAIT; otherwise it SHALL stay in S_REQ with ob_re low.
REQ-024 S_WAIT: on ob_rd_valid, the block SHALL register ob_rd_data and go to S_CHECK; it SHALL wait indefinitely otherwise; at most one read is outstanding.
REQ-025 S_CHECK: the block SHALL compare all 16 lanes in one cycle, add the mismatch popcount (0..16) to error_count saturating at 32'hFFFFFFFF, increment words_checked, and advance the LFSR 16 steps.
REQ-026 First error: on the first word with nonzero mismatches, the block SHALL capture first_err_index=words_checked (pre-increment) and first_err_lane=lowest mismatching lane; later errors SHALL NOT overwrite the capture.
REQ-027 After S_CHECK: go to S_DONE if words_checked+1==word_count, else to S_REQ.
REQ-028 Entering S_DONE: busy SHALL clear, done SHALL set, and pass SHALL equal (error_count==0), all in the same cycle.
REQ-029 start SHALL be ignored while busy; ob_rd_valid SHALL be ignored outside S_WAIT.
REQ-030 Throughput SHALL be one word per 3 cycles minimum (REQ, WAIT, CHECK) when the FIFO is non-empty and valid arrives the cycle after ob_re.
REQ-031 If no error ever occurs, first_err_index and first_err_lane SHALL remain 0.

Reset
REQ-032 While reset_n is low, the block SHALL hold state S_IDLE, and ob_re, busy, done, pass, error_count, first_err_index, first_err_lane and words_checked SHALL all be 0, regardless of clk.
REQ-033 A reset mid-run SHALL abandon the run with no outstanding-read recovery; any late ob_rd_valid after release SHALL be ignored per REQ-029.

Verification
REQ-034 seed=1, word_count=4, FIFO preloaded with a matching LFSR stream -> exactly 4 ob_re pulses; done=1, pass=1, error_count=0, words_checked=4.
REQ-035 As REQ-034 with word 2, lane 5 bit-flipped and word 3, lanes 0 and 15 corrupted -> error_count=3, first_err_index=2, first_err_lane=5, pass=0.
REQ-036 seed=0 -> expected stream identical to seed=1; word_count=0 -> done the cycle after start, no ob_re.
REQ-037 ob_empty held high for 20 cycles mid-run -> ob_re stays 0, busy stays 1; the run completes correctly after empty deasserts.
REQ-038 reset_n pulsed low during S_WAIT -> all outputs 0 immediately; a new start runs cleanly, and a second start while busy is ignored.

Source files
------------

// File: rtl/ddr3_read_checker.sv
// DDR3 read-back checker: pulls 512-bit words from the output-buffer FIFO,
// compares each 32-bit lane against a Galois LFSR reference stream, and
// reports total lane mismatches plus the location of the first one.
module ddr3_read_checker #(
  parameter int          COUNT_WIDTH = 24,
  parameter logic [31:0] LFSR_POLY   = 32'h80200003
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [31:0]            seed,
  input  logic [COUNT_WIDTH-1:0] word_count,
  output logic                   ob_re,
  input  logic [511:0]           ob_rd_data,
  input  logic                   ob_rd_valid,
  input  logic                   ob_empty,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [31:0]            error_count,
  output logic [COUNT_WIDTH-1:0] first_err_index,
  output logic [3:0]             first_err_lane,
  output logic [COUNT_WIDTH-1:0] words_checked
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_CHECK = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  // One Galois LFSR step; the zero state is never reached from a nonzero seed.
  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
  endfunction

  state_e                 state_q, state_d;
  logic [31:0]            lfsr_q, lfsr_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [COUNT_WIDTH-1:0] checked_q, checked_d;
  logic [31:0]            error_q, error_d;
  logic [COUNT_WIDTH-1:0] ferr_idx_q, ferr_idx_d;
  logic [3:0]             ferr_lane_q, ferr_lane_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   pass_q, pass_d;
  logic [511:0]           data_q;
  logic                   data_load;

  // Compare datapath signals (valid while in S_CHECK).
  logic [31:0]            lane_exp;
  logic [15:0]            mismatch;
  logic [4:0]             mis_cnt;
  logic [3:0]             low_lane;
  logic [31:0]            lfsr_adv;
  logic [32:0]            err_sum_wide;
  logic [31:0]            err_sum;
  logic [COUNT_WIDTH-1:0] checked_inc;

  // Lane comparison, mismatch popcount, lowest failing lane and saturating sum.
  always_comb begin
    // NOTE: blocking assignments here are deliberate: lane_exp is walked
    // through 16 LFSR steps in sequence within a single combinational pass.
    lane_exp = lfsr_q;
    mismatch = '0;
    mis_cnt  = '0;
    low_lane = '0;
    for (int i = 0; i < 16; i++) begin
      mismatch[i] = (data_q[i*32 +: 32] != lane_exp);
      lane_exp    = lfsr_next(lane_exp);
    end
    lfsr_adv = lane_exp;
    // Scan downward so the lowest mismatching lane is the one that sticks.
    for (int i = 15; i >= 0; i--) begin
      if (mismatch[i]) low_lane = 4'(i);
    end
    for (int i = 0; i < 16; i++) begin
      mis_cnt = mis_cnt + 5'(mismatch[i]);
    end
    err_sum_wide = {1'b0, error_q} + 33'(mis_cnt);
    err_sum      = err_sum_wide[32] ? 32'hFFFF_FFFF : err_sum_wide[31:0];
    checked_inc  = checked_q + COUNT_WIDTH'(1);
  end

  // Next-state and control decode for the run sequencer.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    target_d    = target_q;
    checked_d   = checked_q;
    error_d     = error_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_lane_d = ferr_lane_q;
    busy_d      = busy_q;
    done_d      = done_q;
    pass_d      = pass_q;
    data_load   = 1'b0;
    ob_re       = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d      = (seed == 32'h0) ? 32'h0000_0001 : seed;
          target_d    = word_count;
          checked_d   = '0;
          error_d     = '0;
          ferr_idx_d  = '0;
          ferr_lane_d = '0;
          pass_d      = 1'b0;
          if (word_count == '0) begin
            // An empty run completes immediately and trivially passes.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = S_REQ;
            busy_d  = 1'b1;
            done_d  = 1'b0;
          end
        end
      end

      S_REQ: begin
        if (!ob_empty) begin
          ob_re   = 1'b1;
          state_d = S_WAIT;
        end
      end

      S_WAIT: begin
        if (ob_rd_valid) begin
          data_load = 1'b1;
          state_d   = S_CHECK;
        end
      end

      S_CHECK: begin
        checked_d = checked_inc;
        error_d   = err_sum;
        lfsr_d    = lfsr_adv;
        // error_q stays nonzero once any mismatch was seen (it saturates),
        // so it doubles as the "first error already captured" flag.
        if (mismatch != '0 && error_q == '0) begin
          ferr_idx_d  = checked_q;
          ferr_lane_d = low_lane;
        end
        if (checked_inc == target_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_sum == '0);
        end else begin
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state is always updated with non-blocking
      // assignments so every register samples its pre-edge inputs.
      state_q     <= S_IDLE;
      lfsr_q      <= 32'h0000_0001;
      target_q    <= '0;
      checked_q   <= '0;
      error_q     <= '0;
      ferr_idx_q  <= '0;
      ferr_lane_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      target_q    <= target_d;
      checked_q   <= checked_d;
      error_q     <= error_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_lane_q <= ferr_lane_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
    end
  end

  // Read-data holding register for the compare cycle.
  always_ff @(posedge clk) begin
    // NOTE: no reset on this wide register: it is only consumed in S_CHECK,
    // which is reachable solely through the S_WAIT cycle that loads it.
    if (data_load) data_q <= ob_rd_data;
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign error_count     = error_q;
  assign first_err_index = ferr_idx_q;
  assign first_err_lane  = ferr_lane_q;
  assign words_checked   = checked_q;

endmodule

// File: tb/tb_ddr3_read_checker.sv
// Self-checking bench for ddr3_read_checker: a FIFO responder model, a
// table of directed runs, hand-written corner sequences and random runs
// scored against a lane-by-lane reference model.
module tb_ddr3_read_checker;

  localparam int          CW   = 24;
  localparam logic [31:0] POLY = 32'h80200003;

  logic          clk;
  logic          reset_n;
  logic          start;
  logic [31:0]   seed;
  logic [CW-1:0] word_count;
  logic          ob_re;
  logic [511:0]  ob_rd_data;
  logic          ob_rd_valid;
  logic          ob_empty;
  logic          busy;
  logic          done;
  logic          pass;
  logic [31:0]   error_count;
  logic [CW-1:0] first_err_index;
  logic [3:0]    first_err_lane;
  logic [CW-1:0] words_checked;

  ddr3_read_checker #(.COUNT_WIDTH(CW), .LFSR_POLY(POLY)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .start           (start),
    .seed            (seed),
    .word_count      (word_count),
    .ob_re           (ob_re),
    .ob_rd_data      (ob_rd_data),
    .ob_rd_valid     (ob_rd_valid),
    .ob_empty        (ob_empty),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .error_count     (error_count),
    .first_err_index (first_err_index),
    .first_err_lane  (first_err_lane),
    .words_checked   (words_checked)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- FIFO model and responder ----------------
  logic [511:0] fifo_q[$];
  logic [511:0] pend_q[$];
  int           read_count  = 0;
  int           fixed_extra = 0;   // extra valid latency; -1 picks randomly

  initial begin
    ob_rd_valid = 1'b0;
    ob_rd_data  = '0;
    ob_empty    = 1'b1;
    forever begin
      logic [511:0] w;
      int           extra;
      @(posedge clk);
      #2;
      ob_empty = (fifo_q.size() == 0);
      @(negedge clk);
      if (ob_re === 1'b1) begin
        read_count++;
        w     = (fifo_q.size() > 0) ? fifo_q.pop_front() : '0;
        extra = (fixed_extra >= 0) ? fixed_extra : int'($urandom_range(0, 2));
        @(posedge clk);
        repeat (extra) @(posedge clk);
        #1;
        ob_rd_valid = 1'b1;
        ob_rd_data  = w;
        @(posedge clk);
        #1;
        ob_rd_valid = 1'b0;
      end
    end
  end

  // ---------------- Reference model ----------------
  logic [15:0] corrupt [64];
  int          exp_err, exp_idx, exp_lane;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? POLY : 32'h0);
  endfunction

  // Builds the FIFO stream from data_seed with corrupt[] applied, pushes the
  // first n_push words (rest go to pend_q), and predicts the DUT results by
  // comparing every lane against the stream the DUT derives from dut_seed.
  task automatic build_run(input logic [31:0] data_seed, input logic [31:0] dut_seed,
                           input int wc, input int n_push);
    logic [31:0]  s, m, lane;
    logic [511:0] word;
    bit           found;
    s = (data_seed == 0) ? 32'h1 : data_seed;
    m = (dut_seed  == 0) ? 32'h1 : dut_seed;
    exp_err = 0; exp_idx = 0; exp_lane = 0; found = 0;
    fifo_q.delete();
    pend_q.delete();
    for (int w = 0; w < wc; w++) begin
      for (int l = 0; l < 16; l++) begin
        lane = s;
        if (corrupt[w][l]) lane = lane ^ (32'h1 << ((w * 7 + l) % 32));
        word[l*32 +: 32] = lane;
        if (lane != m) begin
          exp_err++;
          if (!found) begin
            found = 1; exp_idx = w; exp_lane = l;
          end
        end
        s = lfsr_step(s);
        m = lfsr_step(m);
      end
      if (w < n_push) fifo_q.push_back(word);
      else            pend_q.push_back(word);
    end
  endtask

  task automatic clear_corrupt();
    for (int w = 0; w < 64; w++) corrupt[w] = '0;
  endtask

  task automatic do_start(input logic [31:0] sd, input int wc);
    @(posedge clk);
    #1;
    start      = 1'b1;
    seed       = sd;
    word_count = CW'(wc);
    @(posedge clk);
    #1;
    start      = 1'b0;
  endtask

  // Counts negedges after the start edge until done; bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (done !== 1'b1 && n < 2000);
    check("done_within_budget", 64'(done), 64'(1));
  endtask

  task automatic wait_reads(input int target);
    int k = 0;
    while (read_count < target && k < 500) begin
      @(negedge clk);
      k++;
    end
    check("reads_reached", 64'(read_count >= target), 64'(1));
  endtask

  task automatic check_results(input string tag, input int e_err, input int e_idx,
                               input int e_lane, input int e_pass, input int wc);
    check({tag, "_error_count"}, 64'(error_count), 64'(e_err));
    check({tag, "_first_idx"}, 64'(first_err_index), 64'(e_idx));
    check({tag, "_first_lane"}, 64'(first_err_lane), 64'(e_lane));
    check({tag, "_pass"}, 64'(pass), 64'(e_pass));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_words_checked"}, 64'(words_checked), 64'(wc));
    check({tag, "_ob_re_pulses"}, 64'(read_count), 64'(wc));
  endtask

  // ---------------- Directed vector table ----------------
  typedef struct {
    logic [31:0]      dut_seed;
    logic [31:0]      data_seed;
    int               wc;
    logic [7:0][15:0] masks;
    int               e_err;
    int               e_idx;
    int               e_lane;
    int               e_pass;
  } vec_t;

  vec_t vecs[7];

  function automatic vec_t mkv(input logic [31:0] ds, input logic [31:0] das, input int wc,
                               input int ee, input int ei, input int el, input int ep);
    vec_t v;
    v.dut_seed = ds; v.data_seed = das; v.wc = wc; v.masks = '0;
    v.e_err = ee; v.e_idx = ei; v.e_lane = el; v.e_pass = ep;
    return v;
  endfunction

  initial begin
    int n;
    int bad;
    string tag;

    start = 1'b0; seed = '0; word_count = '0;
    clear_corrupt();

    // Table: clean stream, two-word corruption, seed 0, dense errors,
    // last-lane error, wrong seed (every lane differs), scattered errors.
    vecs[0] = mkv(32'h1,        32'h1,        4, 0,  0, 0,  1);
    vecs[1] = mkv(32'h1,        32'h1,        4, 3,  2, 5,  0);
    vecs[1].masks[2] = 16'h0020;
    vecs[1].masks[3] = 16'h8001;
    vecs[2] = mkv(32'h0,        32'h1,        3, 0,  0, 0,  1);
    vecs[3] = mkv(32'hDEADBEEF, 32'hDEADBEEF, 5, 18, 0, 0,  0);
    vecs[3].masks[0] = 16'h0003;
    vecs[3].masks[4] = 16'hFFFF;
    vecs[4] = mkv(32'h12345678, 32'h12345678, 6, 1,  5, 15, 0);
    vecs[4].masks[5] = 16'h8000;
    vecs[5] = mkv(32'h1,        32'h2,        2, 32, 0, 0,  0);
    vecs[6] = mkv(32'hCAFEF00D, 32'hCAFEF00D, 8, 2,  1, 8,  0);
    vecs[6].masks[1] = 16'h0100;
    vecs[6].masks[6] = 16'h0010;

    // Reset state, checked before any clock edge.
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    check("rst_ob_re", 64'(ob_re), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_pass", 64'(pass), 64'(0));
    check("rst_error_count", 64'(error_count), 64'(0));
    check("rst_words_checked", 64'(words_checked), 64'(0));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Directed table, single-cycle valid latency: also checks 3-cycle throughput.
    fixed_extra = 0;
    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("vec%0d", i);
      clear_corrupt();
      for (int w = 0; w < vecs[i].wc; w++) corrupt[w] = vecs[i].masks[w];
      build_run(vecs[i].data_seed, vecs[i].dut_seed, vecs[i].wc, vecs[i].wc);
      read_count = 0;
      do_start(vecs[i].dut_seed, vecs[i].wc);
      wait_done(n);
      check({tag, "_latency"}, 64'(n), 64'(3 * vecs[i].wc + 1));
      check_results(tag, vecs[i].e_err, vecs[i].e_idx, vecs[i].e_lane,
                    vecs[i].e_pass, vecs[i].wc);
    end

    // word_count == 0: done on the cycle after start, no reads.
    clear_corrupt();
    build_run(32'h5, 32'h5, 0, 0);
    read_count = 0;
    do_start(32'h5, 0);
    wait_done(n);
    check("wc0_latency", 64'(n), 64'(1));
    check_results("wc0", 0, 0, 0, 1, 0);
    repeat (5) @(negedge clk);
    check("done_held", 64'(done), 64'(1));

    // FIFO runs dry mid-run for 20+ cycles.
    clear_corrupt();
    corrupt[3] = 16'h0080;
    build_run(32'hA5A5A5A5, 32'hA5A5A5A5, 4, 2);
    read_count = 0;
    do_start(32'hA5A5A5A5, 4);
    wait_reads(2);
    repeat (4) @(negedge clk);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (ob_re !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("stall_no_re_busy", 64'(bad), 64'(0));
    check("stall_words_checked", 64'(words_checked), 64'(2));
    while (pend_q.size() > 0) fifo_q.push_back(pend_q.pop_front());
    wait_done(n);
    check_results("stall", 1, 3, 7, 0, 4);

    // Reset while waiting on read data; the late valid must be ignored.
    fixed_extra = 4;
    clear_corrupt();
    build_run(32'h1, 32'h1, 3, 3);
    read_count = 0;
    do_start(32'h1, 3);
    wait_reads(1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("midrst_ob_re", 64'(ob_re), 64'(0));
    check("midrst_busy", 64'(busy), 64'(0));
    check("midrst_done", 64'(done), 64'(0));
    check("midrst_error_count", 64'(error_count), 64'(0));
    check("midrst_words_checked", 64'(words_checked), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(negedge clk);
    check("postrst_idle_busy", 64'(busy), 64'(0));
    check("postrst_idle_done", 64'(done), 64'(0));
    check("postrst_words_checked", 64'(words_checked), 64'(0));

    // Fresh run after reset, with an ignored second start while busy.
    fixed_extra = 0;
    clear_corrupt();
    build_run(32'h1, 32'h1, 4, 4);
    read_count = 0;
    do_start(32'h1, 4);
    repeat (2) @(negedge clk);
    do_start(32'h99, 1);
    wait_done(n);
    check_results("restart", 0, 0, 0, 1, 4);

    // Randomized runs scored against the reference model.
    fixed_extra = -1;
    for (int r = 0; r < 15; r++) begin
      logic [31:0] sd;
      int          wc;
      tag = $sformatf("rand%0d", r);
      wc  = int'($urandom_range(1, 10));
      sd  = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom();
      clear_corrupt();
      for (int w = 0; w < wc; w++)
        for (int l = 0; l < 16; l++)
          corrupt[w][l] = ($urandom_range(0, 40) == 0);
      build_run(sd, sd, wc, wc);
      read_count = 0;
      do_start(sd, wc);
      wait_done(n);
      check_results(tag, exp_err, exp_idx, exp_lane, (exp_err == 0) ? 1 : 0, wc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
